// File: rtl/imem_loader.sv
// Boot loader: turns a framed byte stream into 32-bit instruction-memory writes and holds the CPU
// in reset until a complete image is loaded. Optional trailing XOR byte: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int         ADDR_WIDTH = 8,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);
    localparam int                  CNT_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]    IDLE_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]    IDLE_ONE  = CNT_W'(1);
    localparam logic [ADDR_WIDTH:0] WC_ONE    = (ADDR_WIDTH + 1)'(1);
    localparam logic [16:0]         CAPACITY  = 17'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK    = 3'd4,
`endif
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t           state_r;
    logic [15:0]      len_r;
    logic [23:0]      shift_r;
    logic [1:0]       byte_idx_r;
    logic [CNT_W-1:0] idle_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       xor_r;
`endif

    logic        accept_s;
    logic        sync_s;
    logic [15:0] len_s;
    logic        last_write_s;

    assign accept_s     = rx_valid & rx_ready;
    assign sync_s       = accept_s & (rx_data == SYNC_BYTE);
    assign len_s        = {len_r[15:8], rx_data};
    // word_count already includes the word being written during the write cycle
    assign last_write_s = imem_we & (word_count == len_r[ADDR_WIDTH:0]);

    // Frame FSM with registered outputs; the idle/timeout block sits last so an abort wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= S_IDLE;
            len_r      <= 16'd0;
            shift_r    <= 24'd0;
            byte_idx_r <= 2'd0;
            idle_r     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_r      <= 8'd0;
`endif
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= 32'd0;
            cpu_reset  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
        end else begin
            rx_ready <= 1'b1;
            imem_we  <= 1'b0;
            case (state_r)
                S_IDLE, S_DONE, S_ERR: begin
                    if (sync_s) begin
                        state_r    <= S_LEN_HI;
                        busy       <= 1'b1;
                        cpu_reset  <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_r      <= 8'd0;
`endif
                    end else begin
                        state_r <= state_r;
                    end
                end
                S_LEN_HI: begin
                    if (accept_s) begin
                        len_r[15:8] <= rx_data;
                        state_r     <= S_LEN_LO;
                    end else begin
                        state_r <= state_r;
                    end
                end
                S_LEN_LO: begin
                    if (accept_s) begin
                        len_r      <= len_s;
                        byte_idx_r <= 2'd0;
                        if ({1'b0, len_s} > CAPACITY) begin
                            state_r   <= S_ERR;
                            busy      <= 1'b0;
                            error     <= 1'b1;
                            cpu_reset <= 1'b1;
                            done      <= 1'b0;
                        end else if (len_s == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_r   <= S_CHK;
`else
                            state_r   <= S_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
`endif
                        end else begin
                            state_r <= S_DATA;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                S_DATA: begin
                    if (last_write_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_r   <= S_CHK;
`else
                        state_r   <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cpu_reset <= 1'b0;
`endif
                    end else if (accept_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_r <= xor_r ^ rx_data;
`endif
                        if (byte_idx_r == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_waddr <= word_count[ADDR_WIDTH-1:0];
                            imem_wdata <= {shift_r, rx_data};
                            word_count <= word_count + WC_ONE;
                            rx_ready   <= 1'b0;
                            byte_idx_r <= 2'd0;
                        end else begin
                            shift_r    <= {shift_r[15:0], rx_data};
                            byte_idx_r <= byte_idx_r + 2'd1;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (accept_s) begin
                        busy <= 1'b0;
                        if (rx_data == xor_r) begin
                            state_r   <= S_DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state_r   <= S_ERR;
                            error     <= 1'b1;
                            cpu_reset <= 1'b1;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
`endif
                default: begin
                    state_r   <= S_ERR;
                    busy      <= 1'b0;
                    error     <= 1'b1;
                    cpu_reset <= 1'b1;
                    done      <= 1'b0;
                end
            endcase
            // Idle cycles only count while a frame is open; a pending last write completes the frame
            if (accept_s || !busy) begin
                idle_r <= '0;
            end else if ((idle_r == IDLE_LAST) && !last_write_s) begin
                idle_r    <= '0;
                state_r   <= S_ERR;
                busy      <= 1'b0;
                error     <= 1'b1;
                cpu_reset <= 1'b1;
                done      <= 1'b0;
            end else begin
                idle_r <= idle_r + IDLE_ONE;
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a frame-level model predicts writes and final status,
// and a per-cycle monitor checks every write and output invariant against it.
`timescale 1ns/1ps
module tb_imem_loader;
    localparam int         AW   = 8;
    localparam int         TO   = 20;
    localparam logic [7:0] SYNC = 8'hA5;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   word_count;

    int         checks = 0;
    int         failures = 0;
    bit         mon_en = 1'b0;
    wr_t        exp_wr[$];
    logic [7:0] fq[$];
    logic [31:0] mem_bench [0:255];
    logic       exp_done = 1'b0;
    int         exp_wc = 0;
    logic [7:0] last_xor = 8'h00;
    logic [7:0] t2 [0:10] = '{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                              8'h01, 8'h23, 8'h45, 8'h67};

    imem_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(SYNC), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .busy(busy), .done(done),
        .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor_cycle();
        wr_t w;
        check("cpu_reset_vs_done", 64'(cpu_reset), 64'(!done));
        check("rx_ready_bubble", 64'(rx_ready), 64'(!imem_we));
        if (imem_we) begin
            check("we_inside_frame", 64'(busy), 64'd1);
            check("we_expected", 64'(exp_wr.size() != 0), 64'd1);
            if (exp_wr.size() != 0) begin
                w = exp_wr.pop_front();
                check("waddr", 64'(imem_waddr), 64'(w.addr));
                check("wdata", 64'(imem_wdata), 64'(w.data));
                check("word_count_at_write", 64'(word_count), 64'(w.addr) + 64'd1);
            end
            mem_bench[imem_waddr] = imem_wdata;
        end
    endtask

    // Frame model: parse the queued stream and predict writes plus final status
    task automatic predict();
        int i, n, base, words;
        logic [7:0] x;
        logic [31:0] wd;
        wr_t w;
        i = 0;
        while (i < fq.size() && fq[i] != SYNC) i++;
        if (i + 3 > fq.size()) begin
            if (i < fq.size()) begin
                exp_done = 1'b0;
                exp_wc = 0;
            end
            return;
        end
        n = int'({fq[i+1], fq[i+2]});
        base = i + 3;
        exp_wc = 0;
        x = 8'h00;
        if (n > (1 << AW)) begin
            exp_done = 1'b0;
            return;
        end
        words = (fq.size() - base) / 4;
        if (words > n) words = n;
        for (int k = 0; k < words; k++) begin
            wd = {fq[base+4*k], fq[base+4*k+1], fq[base+4*k+2], fq[base+4*k+3]};
            x = x ^ wd[31:24] ^ wd[23:16] ^ wd[15:8] ^ wd[7:0];
            w.addr = AW'(k);
            w.data = wd;
            exp_wr.push_back(w);
        end
        last_xor = x;
        exp_wc = words;
        if (words < n) begin
            exp_done = 1'b0;
        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            exp_done = (fq.size() > base + 4 * n) && (fq[base + 4 * n] == x);
`else
            exp_done = 1'b1;
`endif
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data = b;
        while (!rx_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("byte_accept_wait", 64'(guard < 50), 64'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_all();
        foreach (fq[k]) send_byte(fq[k]);
    endtask

    task automatic build_t2();
        fq.delete();
        foreach (t2[k]) fq.push_back(t2[k]);
    endtask

    task automatic append_chk();
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        for (int k = 3; k < fq.size(); k++) x = x ^ fq[k];
        fq.push_back(x);
`endif
    endtask

    task automatic check_status(input string tag);
        check({tag, "_done"}, 64'(done), 64'(exp_done));
        check({tag, "_error"}, 64'(error), 64'(!exp_done));
        check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(!exp_done));
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_word_count"}, 64'(word_count), 64'(exp_wc));
        check({tag, "_missing_we"}, 64'(exp_wr.size()), 64'd0);
    endtask

    task automatic run_frame(input string tag);
        predict();
        send_all();
        repeat (6) @(negedge clk);
        check_status(tag);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
        check({tag, "_imem_we"}, 64'(imem_we), 64'd0);
        check({tag, "_waddr"}, 64'(imem_waddr), 64'd0);
        check({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
        check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
        check({tag, "_word_count"}, 64'(word_count), 64'd0);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (mon_en && reset_n) monitor_cycle();
            end
        join_none

        // Test 1: reset and release
        repeat (3) @(negedge clk);
        check_reset_values("t1_in_reset");
        reset_n = 1'b1;
        #1;
        check("t1_rx_ready_before_edge", 64'(rx_ready), 64'd0);
        @(posedge clk);
        #1;
        check("t1_rx_ready_after_edge", 64'(rx_ready), 64'd1);
        check("t1_cpu_reset", 64'(cpu_reset), 64'd1);
        mon_en = 1'b1;

        // Test 2: two-word image; XOR of its eight payload bytes is 8'h22
        build_t2();
        append_chk();
        predict();
        check("t2_model_word0", 64'(exp_wr[0].data), 64'h0000_0000_DEAD_BEEF);
        check("t2_model_word1", 64'(exp_wr[1].data), 64'h0000_0000_0123_4567);
        check("t2_model_xor", 64'(last_xor), 64'h22);
        send_all();
        @(negedge clk);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("t2_done_after_chk", 64'(done), 64'd1);
`else
        check("t2_last_we", 64'(imem_we), 64'd1);
        check("t2_done_not_yet", 64'(done), 64'd0);
        @(negedge clk);
        check("t2_done_after_we", 64'(done), 64'd1);
`endif
        repeat (4) @(negedge clk);
        check_status("t2");
        check("t2_mem0", 64'(mem_bench[0]), 64'h0000_0000_DEAD_BEEF);
        check("t2_mem1", 64'(mem_bench[1]), 64'h0000_0000_0123_4567);
        check("t2_word_count", 64'(word_count), 64'd2);

        // Test 3: leading garbage, empty image
        fq.delete();
        fq.push_back(8'h11); fq.push_back(8'h22);
        fq.push_back(SYNC); fq.push_back(8'h00); fq.push_back(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        fq.push_back(8'h00);
`endif
        run_frame("t3");
        check("t3_done_literal", 64'(done), 64'd1);

        // Test 4: length 257 rejected, then a valid frame recovers
        fq.delete();
        fq.push_back(SYNC); fq.push_back(8'h01); fq.push_back(8'h01);
        run_frame("t4_len");
        check("t4_error_literal", 64'(error), 64'd1);
        build_t2();
        append_chk();
        run_frame("t4_recover");

        // Boundary: exactly full memory, last address 255
        fq.delete();
        fq.push_back(SYNC); fq.push_back(8'h01); fq.push_back(8'h00);
        for (int w = 0; w < 256; w++) begin
            fq.push_back(8'(w)); fq.push_back(8'hC3);
            fq.push_back(~8'(w)); fq.push_back(8'h5A);
        end
        append_chk();
        run_frame("tfull");
        check("tfull_mem255", 64'(mem_bench[255]), 64'h0000_0000_FFC3_005A);

        // Test 5: truncated frame times out after exactly TO idle cycles
        fq.delete();
        fq.push_back(SYNC); fq.push_back(8'h00); fq.push_back(8'h01);
        fq.push_back(8'hDE); fq.push_back(8'hAD);
        predict();
        send_all();
        check("t5_busy_mid_frame", 64'(busy), 64'd1);
        repeat (TO) @(negedge clk);
        check("t5_error_not_yet", 64'(error), 64'd0);
        @(negedge clk);
        check("t5_error_at_timeout", 64'(error), 64'd1);
        repeat (3) @(negedge clk);
        check_status("t5");

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Test 6a: bad checksum, words stay written, CPU held
        build_t2();
        fq.push_back(8'h00);
        run_frame("t6_badchk");
        check("t6_cpu_reset_literal", 64'(cpu_reset), 64'd1);
`endif

        // Test 6b: asynchronous reset in the middle of DATA
        build_t2();
        while (fq.size() > 8) void'(fq.pop_back());
        predict();
        send_all();
        check("t6_wc_before_reset", 64'(word_count), 64'd1);
        mon_en = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("t6_async");
        check("t6_queue_drained", 64'(exp_wr.size()), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("t6_rx_ready_release", 64'(rx_ready), 64'd1);
        mon_en = 1'b1;
        build_t2();
        append_chk();
        run_frame("t6_recover");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
